// File: rtl/alu74181_slice_seq_if.sv
// Operand/result bus for the sequential 74181 ALU.
// ALU_ACC_EN adds the acc select that takes operand A from the result register.
interface alu74181_slice_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       s;
  logic             m;
  logic             cn_n;
`ifdef ALU_ACC_EN
  logic             acc;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] f;
  logic             eq;
  logic             cout_n;
  logic             p_n;
  logic             g_n;

  modport master (
    output start, a, b, s, m, cn_n,
`ifdef ALU_ACC_EN
    output acc,
`endif
    input  busy, done, f, eq, cout_n, p_n, g_n
  );

  modport slave (
    input  start, a, b, s, m, cn_n,
`ifdef ALU_ACC_EN
    input  acc,
`endif
    output busy, done, f, eq, cout_n, p_n, g_n
  );
endinterface

// File: rtl/alu74181_slice_seq.sv
// Sequential 74181-function ALU: LANES 4-bit slices per clock, LSB first, registered ripple carry.
// Optional ALU_ACC_EN: start with acc=1 takes operand A from the current f register.
module alu74181_slice_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 1
) (
  input  logic                clk,
  input  logic                rst,
  alu74181_slice_seq_if.slave bus
);
  localparam int unsigned STEP = 4 * LANES;
  localparam int unsigned NCYC = WIDTH / STEP;
  localparam int unsigned IW   = $clog2(NCYC + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, fw_q, fw_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic             carry_q, carry_d;   // active-low, same sense as cn_n
  logic             pw_q, pw_d, gw_q, gw_d, ew_q, ew_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             eq_q, eq_d, cout_n_q, cout_n_d, p_n_q, p_n_d, g_n_q, g_n_d;

  logic [STEP-1:0]  lane_f;
  logic             lane_c, lane_p, lane_g, lane_eq;

  // Evaluate the current LANES slices from the low end of the shifting operand registers.
  always_comb begin : slice_eval
    logic       c;
    logic       sg;
    logic [3:0] a4, b4, u, v, f4;
    c       = ~carry_q;
    sg      = 1'b0;
    a4      = '0;
    b4      = '0;
    u       = '0;
    v       = '0;
    f4      = '0;
    lane_f  = '0;
    lane_p  = pw_q;
    lane_g  = gw_q;
    lane_eq = ew_q;
    for (int unsigned j = 0; j < LANES; j++) begin
      a4 = a_q[4*j +: 4];
      b4 = b_q[4*j +: 4];
      u  = a4 | (b4 & {4{s_q[0]}}) | (~b4 & {4{s_q[1]}});
      v  = (a4 & ~b4 & {4{s_q[2]}}) | (a4 & b4 & {4{s_q[3]}});
      sg = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        f4[i] = m_q ? ~(u[i] ^ v[i]) : (u[i] ^ v[i] ^ c);
        c     = v[i] | (u[i] & c);
        sg    = v[i] | (u[i] & sg);
      end
      lane_f[4*j +: 4] = f4;
      lane_eq = lane_eq & (&f4);
      lane_g  = sg | ((&u) & lane_g);
      lane_p  = lane_p & (&u);
    end
    lane_c = c;
  end

  always_comb begin : fsm_next
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    fw_d     = fw_q;
    s_d      = s_q;
    m_d      = m_q;
    carry_d  = carry_q;
    pw_d     = pw_q;
    gw_d     = gw_q;
    ew_d     = ew_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    f_d      = f_q;
    eq_d     = eq_q;
    cout_n_d = cout_n_q;
    p_n_d    = p_n_q;
    g_n_d    = g_n_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
`ifdef ALU_ACC_EN
          a_d = bus.acc ? f_q : bus.a;
`else
          a_d = bus.a;
`endif
          b_d     = bus.b;
          s_d     = bus.s;
          m_d     = bus.m;
          carry_d = bus.cn_n;
          idx_d   = '0;
          fw_d    = '0;
          pw_d    = 1'b1;
          gw_d    = 1'b0;
          ew_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (idx_q == IW'(NCYC)) begin
          // All slices done: publish the word and its flags together.
          f_d      = fw_q;
          eq_d     = ew_q;
          cout_n_d = carry_q;
          p_n_d    = ~pw_q;
          g_n_d    = ~gw_q;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          a_d     = a_q >> STEP;
          b_d     = b_q >> STEP;
          fw_d    = (fw_q >> STEP) | (WIDTH'(lane_f) << (WIDTH - STEP));
          carry_d = ~lane_c;
          pw_d    = lane_p;
          gw_d    = lane_g;
          ew_d    = lane_eq;
          idx_d   = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      fw_q     <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      carry_q  <= 1'b0;
      pw_q     <= 1'b0;
      gw_q     <= 1'b0;
      ew_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      f_q      <= '0;
      eq_q     <= 1'b0;
      cout_n_q <= 1'b1;
      p_n_q    <= 1'b1;
      g_n_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      fw_q     <= fw_d;
      s_q      <= s_d;
      m_q      <= m_d;
      carry_q  <= carry_d;
      pw_q     <= pw_d;
      gw_q     <= gw_d;
      ew_q     <= ew_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      f_q      <= f_d;
      eq_q     <= eq_d;
      cout_n_q <= cout_n_d;
      p_n_q    <= p_n_d;
      g_n_q    <= g_n_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.f      = f_q;
  assign bus.eq     = eq_q;
  assign bus.cout_n = cout_n_q;
  assign bus.p_n    = p_n_q;
  assign bus.g_n    = g_n_q;
endmodule

// File: tb/tb_alu74181_slice_seq.sv
// Bench for alu74181_slice_seq: word-level 74181 model plus directed vectors (LANES=1 and LANES=2).
module tb_alu74181_slice_seq;
  localparam int unsigned W     = 16;
  localparam int          NCYC1 = 4;

  typedef struct packed {
    logic [15:0] f;
    logic        eq;
    logic        cout_n;
    logic        p_n;
    logic        g_n;
  } res_t;

  localparam res_t RESET_RES = '{f: 16'h0000, eq: 1'b0, cout_n: 1'b1, p_n: 1'b1, g_n: 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  res_t pr;
  int   lat;

  always #5 clk = ~clk;

  alu74181_slice_seq_if #(.WIDTH(W)) bus1 ();
  alu74181_slice_seq_if #(.WIDTH(W)) bus2 ();

  alu74181_slice_seq #(.WIDTH(W), .LANES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  alu74181_slice_seq #(.WIDTH(W), .LANES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Word-level 74181: arithmetic is X + Y + cin from the function table, logic is the table itself.
  function automatic res_t alu_model(input logic [15:0] a, input logic [15:0] b,
                                     input logic [3:0] s, input logic m, input logic cn_n);
    logic [15:0] x, y, lf;
    logic [16:0] sum, gsum;
    logic        cin;
    res_t        r;
    case (s)
      4'd0:  begin x = a;      y = 16'h0000; lf = ~a;        end
      4'd1:  begin x = a | b;  y = 16'h0000; lf = ~(a | b);  end
      4'd2:  begin x = a | ~b; y = 16'h0000; lf = ~a & b;    end
      4'd3:  begin x = 16'h0; y = 16'hFFFF;  lf = 16'h0000;  end
      4'd4:  begin x = a;      y = a & ~b;   lf = ~(a & b);  end
      4'd5:  begin x = a | b;  y = a & ~b;   lf = ~b;        end
      4'd6:  begin x = a;      y = ~b;       lf = a ^ b;     end
      4'd7:  begin x = a & ~b; y = 16'hFFFF; lf = a & ~b;    end
      4'd8:  begin x = a;      y = a & b;    lf = ~a | b;    end
      4'd9:  begin x = a;      y = b;        lf = ~(a ^ b);  end
      4'd10: begin x = a | ~b; y = a & b;    lf = b;         end
      4'd11: begin x = a & b;  y = 16'hFFFF; lf = a & b;     end
      4'd12: begin x = a;      y = a;        lf = 16'hFFFF;  end
      4'd13: begin x = a | b;  y = a;        lf = a | ~b;    end
      4'd14: begin x = a | ~b; y = a;        lf = a | b;     end
      default: begin x = a;    y = 16'hFFFF; lf = a;         end
    endcase
    cin      = ~cn_n;
    sum      = 17'(x) + 17'(y) + 17'(cin);
    gsum     = 17'(x) + 17'(y);
    r.f      = m ? lf : sum[15:0];
    r.eq     = &r.f;
    r.cout_n = ~sum[16];
    r.p_n    = ~(&(x | y));
    r.g_n    = ~gsum[16];
    return r;
  endfunction

  // Reference for dut1: accepted start -> result published NCYC1+1 edges later.
  logic m_busy, m_done;
  int   m_rem;
  res_t m_out, m_pend;

  always @(posedge clk or posedge rst) begin : ref_model
    logic [15:0] a_sel;
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_rem  <= 0;
      m_out  <= RESET_RES;
      m_pend <= RESET_RES;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_rem == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_out  <= m_pend;
        end
        m_rem <= m_rem - 1;
      end else if (bus1.start) begin
        a_sel = bus1.a;
`ifdef ALU_ACC_EN
        if (bus1.acc) a_sel = m_out.f;
`endif
        m_busy <= 1'b1;
        m_rem  <= NCYC1 + 1;
        m_pend <= alu_model(a_sel, bus1.b, bus1.s, bus1.m, bus1.cn_n);
      end
    end
  end

  always @(negedge clk) begin : compare
    check("busy",   32'(bus1.busy),   32'(m_busy));
    check("done",   32'(bus1.done),   32'(m_done));
    check("f",      32'(bus1.f),      32'(m_out.f));
    check("eq",     32'(bus1.eq),     32'(m_out.eq));
    check("cout_n", 32'(bus1.cout_n), 32'(m_out.cout_n));
    check("p_n",    32'(bus1.p_n),    32'(m_out.p_n));
    check("g_n",    32'(bus1.g_n),    32'(m_out.g_n));
  end

  task automatic drive1(input logic [15:0] av, input logic [15:0] bv, input logic [3:0] sv,
                        input logic mv, input logic cv);
    bus1.a = av; bus1.b = bv; bus1.s = sv; bus1.m = mv; bus1.cn_n = cv;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
  endtask

  task automatic wait_done1(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus1.done !== 1'b1 && n < 20);
    check("done1_seen", 32'(bus1.done), 32'd1);
  endtask

  task automatic run2(input logic [15:0] av, input logic [15:0] bv, input logic [3:0] sv,
                      input logic mv, input logic cv, output int n);
    bus2.a = av; bus2.b = bv; bus2.s = sv; bus2.m = mv; bus2.cn_n = cv;
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus2.done !== 1'b1 && n < 20);
    check("done2_seen", 32'(bus2.done), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.s = '0; bus1.m = 1'b0; bus1.cn_n = 1'b1;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.s = '0; bus2.m = 1'b0; bus2.cn_n = 1'b1;
`ifdef ALU_ACC_EN
    bus1.acc = 1'b0;
    bus2.acc = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Hand-computed values pinning the model
    pr = alu_model(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1);
    check("pin_add_f", 32'(pr.f), 32'h2233);
    check("pin_add_c", 32'(pr.cout_n), 32'd1);
    pr = alu_model(16'hFFFF, 16'h0000, 4'b1001, 1'b0, 1'b0);
    check("pin_wrap", 32'({pr.f, pr.cout_n, pr.p_n, pr.g_n}), 32'({16'h0000, 1'b0, 1'b0, 1'b1}));
    pr = alu_model(16'h0005, 16'h0007, 4'b0110, 1'b0, 1'b0);
    check("pin_sub", 32'({pr.f, pr.cout_n}), 32'({16'hFFFE, 1'b1}));
    pr = alu_model(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1);
    check("pin_xor", 32'(pr.f), 32'h0FF0);
    pr = alu_model(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1);
    check("pin_gen", 32'({pr.f, pr.cout_n, pr.p_n, pr.g_n}), 32'({16'h0000, 1'b0, 1'b0, 1'b0}));

    rst = 1'b0;
    check("rst_state", 32'({bus1.busy, bus1.done, bus1.f, bus1.eq, bus1.cout_n, bus1.p_n, bus1.g_n}),
          32'({1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1}));

    // Add with latency
    drive1(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1);
    wait_done1(lat);
    check("add_lat", 32'(lat), 32'(NCYC1 + 1));
    check("add_f", 32'(bus1.f), 32'h2233);
    check("add_cout", 32'(bus1.cout_n), 32'd1);

    // Wrap and borrow
    drive1(16'hFFFF, 16'h0000, 4'b1001, 1'b0, 1'b0);
    wait_done1(lat);
    check("wrap", 32'({bus1.f, bus1.cout_n}), 32'({16'h0000, 1'b0}));
    drive1(16'h0005, 16'h0007, 4'b0110, 1'b0, 1'b0);
    wait_done1(lat);
    check("borrow", 32'({bus1.f, bus1.cout_n}), 32'({16'hFFFE, 1'b1}));
    drive1(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1);
    wait_done1(lat);
    check("ripple", 32'(bus1.f), 32'h0100);

    // Compare
    drive1(16'hBEEF, 16'hBEEF, 4'b0110, 1'b0, 1'b1);
    wait_done1(lat);
    check("cmp_eq", 32'({bus1.f, bus1.eq}), 32'({16'hFFFF, 1'b1}));
    drive1(16'hBEEF, 16'hBEEE, 4'b0110, 1'b0, 1'b1);
    wait_done1(lat);
    check("cmp_ne", 32'({bus1.f, bus1.eq}), 32'({16'h0000, 1'b0}));

    // Logic op, start while busy ignored, back-to-back start in done cycle
    drive1(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    drive1(16'h0000, 16'h0000, 4'b0000, 1'b1, 1'b1);
    wait_done1(lat);
    check("busy_ign_lat", 32'(lat), 32'd2);
    check("logic_xor", 32'(bus1.f), 32'h0FF0);
    drive1(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1);
    wait_done1(lat);
    check("b2b_lat", 32'(lat), 32'(NCYC1 + 1));
    check("b2b_f", 32'(bus1.f), 32'h2233);

    // Every function code in both modes
    for (int sv = 0; sv < 16; sv++) begin
      for (int mv = 0; mv < 2; mv++) begin
        drive1(16'hA5C3, 16'h3C96, 4'(sv), 1'(mv), 1'(sv ^ mv));
        wait_done1(lat);
      end
    end

    // Reset two cycles into RUN
    drive1(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst", 32'({bus1.busy, bus1.done, bus1.f, bus1.cout_n, bus1.p_n, bus1.g_n}),
          32'({1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1}));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_done_after_rst", 32'(bus1.done), 32'd0);
    end
    drive1(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1);
    wait_done1(lat);
    check("post_rst_f", 32'(bus1.f), 32'h2233);

    // Two lanes per clock
    run2(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, lat);
    check("l2_lat", 32'(lat), 32'd3);
    check("l2_xor", 32'(bus2.f), 32'h0FF0);
    run2(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, lat);
    pr = alu_model(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1);
    check("l2_add", 32'({bus2.f, bus2.eq, bus2.cout_n, bus2.p_n, bus2.g_n}), 32'(pr));
    run2(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, lat);
    check("l2_gen", 32'({bus2.f, bus2.cout_n, bus2.p_n, bus2.g_n}), 32'({16'h0000, 1'b0, 1'b0, 1'b0}));

`ifdef ALU_ACC_EN
    // Accumulate: second operation takes A from the result register
    drive1(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b1);
    wait_done1(lat);
    check("acc_first", 32'(bus1.f), 32'h0002);
    bus1.acc = 1'b1;
    drive1(16'h1234, 16'h0003, 4'b1001, 1'b0, 1'b1);
    bus1.acc = 1'b0;
    wait_done1(lat);
    check("acc_second", 32'(bus1.f), 32'h0005);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
